// File: rtl/fixed_cordic_cos.sv
// Iterative CORDIC cosine on sign / 1 integer / 19 fraction fixed point, one micro-rotation per clock.
// Define CORDIC_SINE_EN to also expose sin(x) taken from the final y.
module fixed_cordic_cos #(
   parameter int ITERATIONS = 20,
   parameter int GUARD_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_i,
   input  logic        integer_i,
   input  logic [18:0] fractional_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign_o,
   output logic        integer_o,
   output logic [18:0] fractional_o
`ifdef CORDIC_SINE_EN
   ,
   output logic        sin_sign_o,
   output logic        sin_integer_o,
   output logic [18:0] sin_fractional_o
`endif
);
   localparam int FW = 19 + GUARD_W;
   localparam int IW = 2 + FW;
   localparam int CW = $clog2(ITERATIONS);
   localparam logic [CW-1:0] LAST    = CW'(ITERATIONS - 1);
   localparam logic [19:0]   HALF_PI = 20'hC90FE;
   localparam logic [20:0]   PI      = 21'h1921FB;

   function automatic logic signed [IW-1:0] to_fix(input real r);
      return IW'($rtoi(r * (2.0 ** FW) + 0.5));
   endfunction

   localparam logic signed [IW-1:0] K = to_fix(0.6072529350);
   localparam logic signed [IW-1:0] ATAN [0:23] = '{
      to_fix(0.78539816339744831), to_fix(0.46364760900080612),
      to_fix(0.24497866312686414), to_fix(0.12435499454676144),
      to_fix(0.06241880999595735), to_fix(0.03123983343026828),
      to_fix(0.01562372862047683), to_fix(0.00781234106010111),
      to_fix(0.00390623013196697), to_fix(0.00195312251647882),
      to_fix(0.00097656218955932), to_fix(0.00048828121119490),
      to_fix(0.00024414062014936), to_fix(0.00012207031189367),
      to_fix(0.00006103515617421), to_fix(0.00003051757811553),
      to_fix(0.00001525878906132), to_fix(0.00000762939453110),
      to_fix(0.00000381469726561), to_fix(0.00000190734863281),
      to_fix(0.00000095367431641), to_fix(0.00000047683715820),
      to_fix(0.00000023841857910), to_fix(0.00000011920928955)};

   // |v| rounded half-up to 19 fraction bits, clamped to 1.0; bit 19 is the integer bit.
   function automatic logic [19:0] round_sat(input logic signed [IW-1:0] v);
      logic [IW-1:0] mag;
      logic [IW-1:0] rnd;
      mag = v[IW-1] ? IW'(-v) : IW'(v);
      rnd = mag + (IW'(1) << (GUARD_W - 1));
      if (rnd[IW-1:GUARD_W] >= (IW-GUARD_W)'(20'h80000)) return 20'h80000;
      return rnd[GUARD_W+19:GUARD_W];
   endfunction

   typedef enum logic [1:0] {IDLE, REDUCE, ITER, DONE} state_t;
   state_t state, state_nx;

   logic [19:0]          ang;
   logic                 neg;
   logic [CW-1:0]        iter;
   logic signed [IW-1:0] x, y, z, x_nx, y_nx, z_nx, z0;
   logic [19:0]          z_red, cmag;

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = REDUCE;
         end
         REDUCE: state_nx = ITER;
         ITER: if (iter == LAST) state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Fold angles past pi/2 onto pi-m so the rotation stays inside CORDIC convergence.
   always_comb begin
      z_red = (ang > HALF_PI) ? 20'(PI - 21'(ang)) : ang;
      z0    = signed'({1'b0, z_red, {GUARD_W{1'b0}}});
   end

   always_comb begin
      if (!z[IW-1]) begin
         x_nx = x - (y >>> iter);
         y_nx = y + (x >>> iter);
         z_nx = z - ATAN[5'(iter)];
      end else begin
         x_nx = x + (y >>> iter);
         y_nx = y - (x >>> iter);
         z_nx = z + ATAN[5'(iter)];
      end
      cmag = round_sat(x_nx);
   end

`ifdef CORDIC_SINE_EN
   logic        ang_sign;
   logic [19:0] smag;
   always_comb smag = round_sat(y_nx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ang_sign         <= 1'b0;
         sin_sign_o       <= 1'b0;
         sin_integer_o    <= 1'b0;
         sin_fractional_o <= '0;
      end else if (state == IDLE && in_valid) begin
         ang_sign <= sign_i;
      end else if (state == ITER && iter == LAST) begin
         sin_sign_o       <= ang_sign & (|smag);
         sin_integer_o    <= smag[19];
         sin_fractional_o <= smag[18:0];
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ang          <= '0;
         neg          <= 1'b0;
         iter         <= '0;
         x            <= '0;
         y            <= '0;
         z            <= '0;
         sign_o       <= 1'b0;
         integer_o    <= 1'b0;
         fractional_o <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (in_valid) ang <= {integer_i, fractional_i};
            REDUCE: begin
               neg  <= (ang > HALF_PI);
               x    <= K;
               y    <= '0;
               z    <= z0;
               iter <= '0;
            end
            ITER: begin
               x    <= x_nx;
               y    <= y_nx;
               z    <= z_nx;
               iter <= iter + 1'b1;
               if (iter == LAST) begin
                  sign_o       <= neg & (|cmag);
                  integer_o    <= cmag[19];
                  fractional_o <= cmag[18:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule
